// File: rtl/simd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | simd_pkg: shared sample/pair types for the radix-2 butterfly datapath |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package simd_pkg;

   localparam int SAMPLE_W  = 15;
   localparam int BFLY_SPAN = 8;
   localparam int SPAN_AW   = $clog2(BFLY_SPAN);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Operand pair as seen by butterfly2r wrappers and the re-serializer.
   typedef struct packed {
      sample_t            a;
      sample_t            b;
      logic [SPAN_AW-1:0] idx;
      logic               last;
   } pair_t;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_PAIR = 1'b1
   } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/pair_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pair_mem: D x W register file, sync write / async read, one address   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pair_mem
   import simd_pkg::*;
#(
   parameter int W  = SAMPLE_W,
   parameter int D  = BFLY_SPAN,
   parameter int AW = $clog2(D)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [D];

   // Contents are not reset; every entry is rewritten in FILL before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/bfly_pair_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bfly_pair_buffer: forms (x[k], x[k+D]) operand pairs from a stream    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bfly_pair_buffer
   import simd_pkg::*;
#(
   parameter int W  = SAMPLE_W,
   parameter int D  = BFLY_SPAN,
   parameter int AW = $clog2(D)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_a,
   output logic [W-1:0]  out_b,
   output logic [AW-1:0] out_idx,
   output logic          out_last
);

   buf_state_t    state, state_nxt;
   logic [AW-1:0] idx, idx_nxt;
   logic          idx_at_end;
   logic          mem_we;
   logic          load_pair;
   logic [W-1:0]  mem_rdata;

   assign idx_at_end = (idx == AW'(D - 1));

   pair_mem #(
      .W  (W),
      .D  (D),
      .AW (AW)
   ) u_pair_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (idx),
      .wdata (in_data),
      .rdata (mem_rdata)
   );

   // D is a power of two, so idx wraps to 0 on its own after D-1.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      in_ready  = 1'b1;
      mem_we    = 1'b0;
      load_pair = 1'b0;
      case (state)
         ST_FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mem_we  = 1'b1;
               idx_nxt = idx + 1'b1;
               if (idx_at_end) begin
                  state_nxt = ST_PAIR;
               end
            end
         end
         ST_PAIR: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready) begin
               load_pair = 1'b1;
               idx_nxt   = idx + 1'b1;
               if (idx_at_end) begin
                  state_nxt = ST_FILL;
               end
            end
         end
         default: begin
            state_nxt = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FILL;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // A load in the same cycle as a drain simply replaces the pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else if (load_pair) begin
         out_valid <= 1'b1;
         out_a     <= mem_rdata;
         out_b     <= in_data;
         out_idx   <= idx;
         out_last  <= idx_at_end;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
